// File: rtl/csa_pkg.sv
// Shared sizing, stage-count helper and pipeline slot type for the CSA resolve pipe.
package csa_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_CHUNK = 4;

  // Number of ripple slices; divisibility is checked where the pipe is built.
  function automatic int unsigned nstages(input int unsigned width, input int unsigned chunk);
    return width / chunk;
  endfunction

  // One pipeline slot: partial result plus the operand bits still to be resolved.
  typedef struct packed {
    logic                   valid;
    logic                   carry;
    logic [DEF_WIDTH:0]     b;
    logic [DEF_WIDTH-1:0]   sum;
    logic [DEF_WIDTH+1:0]   res;
  } slot_t;

endpackage

// File: rtl/csa_chunk_stage.sv
// One CHUNK-bit ripple slice with its slot register; the last slice also forms the two result MSBs.
module csa_chunk_stage
  import csa_pkg::*;
#(
  parameter int unsigned K     = 0,
  parameter int unsigned CHUNK = DEF_CHUNK,
  parameter bit          LAST  = 1'b0
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  en,
  input  logic  clr,
  input  slot_t d,
  output slot_t q
);

  localparam int unsigned AW = CHUNK + 1;
  localparam int unsigned LO = K * CHUNK;

  logic [AW-1:0] add;
  slot_t         nxt;

  // Resolve this slice and forward everything else unchanged.
  always_comb begin
    nxt = d;
    add = {1'b0, d.sum[LO +: CHUNK]} + {1'b0, d.b[LO +: CHUNK]} + AW'(d.carry);
    nxt.res[LO +: CHUNK] = add[CHUNK-1:0];
    nxt.carry            = add[CHUNK];
    if (LAST) begin
      nxt.res[DEF_WIDTH]   = d.b[DEF_WIDTH] ^ add[CHUNK];
      nxt.res[DEF_WIDTH+1] = d.b[DEF_WIDTH] & add[CHUNK];
    end
  end

  // Slot register: flush kills the valid bit regardless of enable, stall holds everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q.valid <= 1'b0;
    end else if (en) begin
      q <= nxt;
    end
  end

endmodule

// File: rtl/csa_resolve_pipe.sv
// Pipelined carry-propagate resolve of a carry-save (sum, carry) pair into one binary result.
// Optional synchronous flush port enabled by defining CSA_RESOLVE_FLUSH_EN.
module csa_resolve_pipe
  import csa_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic [WIDTH-1:0] in_ca,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH+1:0] out_res
`ifdef CSA_RESOLVE_FLUSH_EN
  ,
  input  logic             flush
`endif
);

  localparam int unsigned NSTAGES = nstages(WIDTH, CHUNK);

  // Configuration sanity: slices must tile the width, and the slot type is sized by the package.
  if (((WIDTH % CHUNK) != 0) || (WIDTH != DEF_WIDTH)) begin : g_bad_cfg
    $error("csa_resolve_pipe: WIDTH must be a multiple of CHUNK and equal DEF_WIDTH");
  end

  logic  en;
  logic  clr;
  slot_t din;
  slot_t slot_q [NSTAGES];

`ifdef CSA_RESOLVE_FLUSH_EN
  assign clr = flush;
`else
  assign clr = 1'b0;
`endif

  // Whole pipe advances together whenever the output slot is empty or being drained.
  assign en       = !out_valid | out_ready;
  assign in_ready = en & !clr;

  // Build the entry slot; operands are zeroed on empty slots so nothing undefined enters the pipe.
  always_comb begin
    din       = '0;
    din.valid = in_valid & in_ready;
    if (in_valid) begin
      din.sum = in_sum;
      din.b   = {in_ca, 1'b0};
    end
  end

  // One ripple slice per stage; the last stage's slot is the output register.
  for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      csa_chunk_stage #(
        .K     (k),
        .CHUNK (CHUNK),
        .LAST  (NSTAGES == 1)
      ) u_stage (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .clr   (clr),
        .d     (din),
        .q     (slot_q[k])
      );
    end else begin : g_next
      csa_chunk_stage #(
        .K     (k),
        .CHUNK (CHUNK),
        .LAST  (k == NSTAGES - 1)
      ) u_stage (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .clr   (clr),
        .d     (slot_q[k-1]),
        .q     (slot_q[k])
      );
    end
  end

  assign out_valid = slot_q[NSTAGES-1].valid;
  assign out_res   = slot_q[NSTAGES-1].res;

endmodule

// File: tb/tb_csa_resolve_pipe.sv
// Directed bench for csa_resolve_pipe: reset state, single-pair latency/values, stalled stream, mid-flight reset/flush.
module tb_csa_resolve_pipe;

  localparam int unsigned W = 16;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_sum;
  logic [W-1:0] in_ca;
  logic         out_valid;
  logic         out_ready;
  logic [W+1:0] out_res;
`ifdef CSA_RESOLVE_FLUSH_EN
  logic         flush;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  csa_resolve_pipe u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .in_ca     (in_ca),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res)
`ifdef CSA_RESOLVE_FLUSH_EN
    ,
    .flush     (flush)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Send one pair with the pipe empty, then check latency and result.
  task automatic send_one(input string tag, input logic [W-1:0] s, input logic [W-1:0] c,
                          input logic [31:0] exp);
    int lat;
    in_valid = 1'b1;
    in_sum   = s;
    in_ca    = c;
    #1;
    check({tag, "_rdy"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_sum   = '0;
    in_ca    = '0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'd4);
    check(tag, 32'(out_res), exp);
    @(posedge clk); #1;
  endtask

  // Count any results appearing over a window after the pipe was emptied.
  task automatic expect_silence(input string tag);
    int seen;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check(tag, 32'(seen), 32'd0);
  endtask

  // Push three pairs into the pipe and advance until the first reaches the output.
  task automatic fill_three();
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_sum = W'(i + 1);
      in_ca  = W'(i + 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_sum   = '0;
    in_ca    = '0;
    @(posedge clk); #1;
  endtask

  initial begin
    int idx;
    int got;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sum    = '0;
    in_ca     = '0;
    out_ready = 1'b1;
`ifdef CSA_RESOLVE_FLUSH_EN
    flush     = 1'b0;
`endif

    // Reset state, during and after reset.
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_res",   32'(out_res),   32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready",  32'(in_ready),  32'd1);
    check("post_rst_out_valid", 32'(out_valid), 32'd0);
    check("post_rst_out_res",   32'(out_res),   32'd0);

    // Directed single pairs.
    send_one("zero",      16'h0000, 16'h0000, 32'h00000);
    send_one("all_ones",  16'hFFFF, 16'hFFFF, 32'h2FFFD);
    send_one("ripple",    16'h0001, 16'h7FFF, 32'h0FFFF);
    send_one("ca_msb",    16'h0000, 16'h8000, 32'h10000);
    send_one("msb_nocar", 16'hFFFF, 16'h8000, 32'h1FFFF);
    send_one("msb_carry", 16'h8000, 16'hC000, 32'h20000);

    // Six back-to-back pairs with a three-cycle consumer stall.
    idx = 0;
    got = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      out_ready = !(cyc >= 5 && cyc < 8);
      in_valid  = (idx < 6);
      in_sum    = W'(idx + 1);
      in_ca     = W'(idx + 1);
      #1;
      if (!out_ready && out_valid) check("stall_in_ready", 32'(in_ready), 32'd0);
      if (in_valid && in_ready) idx++;
      if (out_valid && out_ready) begin
        check("stream_res", 32'(out_res), 32'(3 * (got + 1)));
        got++;
      end
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    in_sum    = '0;
    in_ca     = '0;
    out_ready = 1'b1;
    check("stream_sent",  32'(idx), 32'd6);
    check("stream_count", 32'(got), 32'd6);

    // Asynchronous reset with pairs in flight.
    fill_three();
    check("prerst_out_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_res",   32'(out_res),   32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    expect_silence("midrst_no_stale");

`ifdef CSA_RESOLVE_FLUSH_EN
    // Flush with pairs in flight, while a new pair is offered.
    fill_three();
    check("preflush_out_valid", 32'(out_valid), 32'd1);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_sum   = 16'h0009;
    in_ca    = 16'h0009;
    #1;
    check("flush_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    in_sum   = '0;
    in_ca    = '0;
    check("flush_out_valid", 32'(out_valid), 32'd0);
    expect_silence("flush_no_stale");
`endif

    // Pipe still works after the disruption.
    send_one("after_kill", 16'h1234, 16'h0101, 32'h01436);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
